elastic_config_loader: RTL

- Initiator of the elastic PE configuration-load interface.
- On command, walks a linear config image in a config memory with a synchronous 1-cycle read. Unpacks each context entry and writes it into PE_NUM PEs over a shared config bus with a one-hot write strobe.
- Then broadcasts mapping_context_max_id and a single-cycle start_exec.
- Sits between the host/config memory and the PE array, one level above the PEs.

---
 rtl/elastic_config_loader_pkg.sv | 40 ++++
 rtl/elastic_config_loader_unpacker.sv | 24 ++
 rtl/elastic_config_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/elastic_config_loader_pkg.sv
`default_nettype none
// elastic_config_loader_pkg: widths, config-entry layout, word0 field offsets and loader FSM states
// shared between the config loader and the PE array.
package elastic_config_loader_pkg;

  localparam int CFG_PE_NUM                  = 4;
  localparam int CFG_DATA_WIDTH              = 32;
  localparam int CFG_ADDRESS_WIDTH           = 32;
  localparam int CFG_NEIGHBOR_PE_NUM         = 4;
  localparam int CFG_INPUT_NUM_BIT_LENGTH    = 3;
  localparam int CFG_OPERATION_BIT_LENGTH    = 4;
  localparam int CFG_CONTEXT_SIZE            = 16;
  localparam int CFG_CONTEXT_SIZE_BIT_LENGTH = 4;

  // word0 layout, LSB first: op, output mask, in2 select, in1 select
  localparam int CFG_OP_LSB     = 0;
  localparam int CFG_MASK_LSB   = CFG_OP_LSB + CFG_OPERATION_BIT_LENGTH;
  localparam int CFG_IN2_LSB    = CFG_MASK_LSB + CFG_NEIGHBOR_PE_NUM;
  localparam int CFG_IN1_LSB    = CFG_IN2_LSB + CFG_INPUT_NUM_BIT_LENGTH;
  localparam int CFG_WORD0_USED = CFG_IN1_LSB + CFG_INPUT_NUM_BIT_LENGTH;

  typedef struct packed {
    logic [CFG_INPUT_NUM_BIT_LENGTH-1:0] in1;
    logic [CFG_INPUT_NUM_BIT_LENGTH-1:0] in2;
    logic [CFG_NEIGHBOR_PE_NUM-1:0]      out_mask;
    logic [CFG_OPERATION_BIT_LENGTH-1:0] op;
    logic [CFG_DATA_WIDTH-1:0]           const_data;
  } config_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_REQ1  = 3'd2,
    ST_CAP   = 3'd3,
    ST_WRITE = 3'd4,
    ST_START = 3'd5
  } load_state_e;

endpackage
`default_nettype wire

// File: rtl/elastic_config_loader_unpacker.sv
`default_nettype none
// config_word_unpacker: splits an image word0 into the PE config-entry fields.
// const_data is left at zero; it arrives in the second image word.
module config_word_unpacker
  import elastic_config_loader_pkg::*;
(
  input  logic [CFG_DATA_WIDTH-1:0] word0,
  output config_entry_t             entry
);

  logic word0_high_unused;

  always_comb begin
    entry          = '0;
    entry.op       = word0[CFG_OP_LSB   +: CFG_OPERATION_BIT_LENGTH];
    entry.out_mask = word0[CFG_MASK_LSB +: CFG_NEIGHBOR_PE_NUM];
    entry.in2      = word0[CFG_IN2_LSB  +: CFG_INPUT_NUM_BIT_LENGTH];
    entry.in1      = word0[CFG_IN1_LSB  +: CFG_INPUT_NUM_BIT_LENGTH];
  end

  assign word0_high_unused = ^word0[CFG_DATA_WIDTH-1:CFG_WORD0_USED];

endmodule
`default_nettype wire

// File: rtl/elastic_config_loader.sv
`default_nettype none
// elastic_config_loader: walks a two-word-per-entry config image, writes every context of every PE
// over the shared config bus, then broadcasts the max context id and a one-cycle start_exec.
module elastic_config_loader
  import elastic_config_loader_pkg::*;
#(
  parameter int PE_NUM                  = CFG_PE_NUM,
  parameter int DATA_WIDTH              = CFG_DATA_WIDTH,
  parameter int ADDRESS_WIDTH           = CFG_ADDRESS_WIDTH,
  parameter int NEIGHBOR_PE_NUM         = CFG_NEIGHBOR_PE_NUM,
  parameter int INPUT_NUM_BIT_LENGTH    = CFG_INPUT_NUM_BIT_LENGTH,
  parameter int OPERATION_BIT_LENGTH    = CFG_OPERATION_BIT_LENGTH,
  parameter int CONTEXT_SIZE            = CFG_CONTEXT_SIZE,
  parameter int CONTEXT_SIZE_BIT_LENGTH = CFG_CONTEXT_SIZE_BIT_LENGTH
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start_load,
  input  logic [ADDRESS_WIDTH-1:0]           base_address,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] context_max_id_in,
  output logic                               memory_read,
  output logic [ADDRESS_WIDTH-1:0]           memory_read_address,
  input  logic [DATA_WIDTH-1:0]              memory_read_data,
  output logic [PE_NUM-1:0]                  write_config_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
  output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
  output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
  output logic [DATA_WIDTH-1:0]              config_const_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
  output logic                               start_exec,
  output logic                               busy
);

  localparam int PW = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam logic [CONTEXT_SIZE_BIT_LENGTH-1:0] MAX_CTX = CONTEXT_SIZE_BIT_LENGTH'(CONTEXT_SIZE - 1);
  localparam logic [PW-1:0] LAST_PE = PW'(PE_NUM - 1);

  load_state_e                        state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]           ptr_q, ptr_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_q, max_id_d;
  logic [PW-1:0]                      pe_q, pe_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] ctx_q, ctx_d;
  config_entry_t                      field_q, field_d;

  logic                               memory_read_q, memory_read_d;
  logic [ADDRESS_WIDTH-1:0]           memory_read_address_q, memory_read_address_d;
  logic [PE_NUM-1:0]                  write_config_data_q, write_config_data_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index_q, config_index_d;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    config_in1_q, config_in1_d;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    config_in2_q, config_in2_d;
  logic [NEIGHBOR_PE_NUM-1:0]         config_out_q, config_out_d;
  logic [OPERATION_BIT_LENGTH-1:0]    config_op_q, config_op_d;
  logic [DATA_WIDTH-1:0]              config_const_q, config_const_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_q, mapping_d;
  logic                               start_exec_q, start_exec_d;
  logic                               busy_q, busy_d;

  config_entry_t                      unpacked;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_sat;
  logic                               const_slot_unused;

  config_word_unpacker u_unpacker (
    .word0 (memory_read_data),
    .entry (unpacked)
  );

  assign max_id_sat = (context_max_id_in > MAX_CTX) ? MAX_CTX : context_max_id_in;
  // const_data travels straight from memory into config_const_q; this slot stays idle
  assign const_slot_unused = ^field_q.const_data;

  always_comb begin
    state_d               = state_q;
    ptr_d                 = ptr_q;
    max_id_d              = max_id_q;
    pe_d                  = pe_q;
    ctx_d                 = ctx_q;
    field_d               = field_q;
    memory_read_address_d = memory_read_address_q;
    write_config_data_d   = '0;
    config_index_d        = config_index_q;
    config_in1_d          = config_in1_q;
    config_in2_d          = config_in2_q;
    config_out_d          = config_out_q;
    config_op_d           = config_op_q;
    config_const_d        = config_const_q;
    mapping_d             = mapping_q;

    case (state_q)
      ST_IDLE: begin
        if (start_load) begin
          ptr_d     = base_address;
          max_id_d  = max_id_sat;
          mapping_d = max_id_sat;
          pe_d      = '0;
          ctx_d     = '0;
          state_d   = ST_REQ0;
        end
      end
      ST_REQ0: state_d = ST_REQ1;
      ST_REQ1: begin
        field_d = unpacked;
        state_d = ST_CAP;
      end
      ST_CAP: begin
        // bus registers load here so they change exactly as WRITE begins
        write_config_data_d = PE_NUM'(1) << pe_q;
        config_index_d      = ctx_q;
        config_in1_d        = field_q.in1;
        config_in2_d        = field_q.in2;
        config_out_d        = field_q.out_mask;
        config_op_d         = field_q.op;
        config_const_d      = memory_read_data;
        state_d             = ST_WRITE;
      end
      ST_WRITE: begin
        ptr_d = ptr_q + ADDRESS_WIDTH'(2);
        if (ctx_q == max_id_q) begin
          ctx_d = '0;
          if (pe_q == LAST_PE) begin
            state_d = ST_START;
          end else begin
            pe_d    = pe_q + PW'(1);
            state_d = ST_REQ0;
          end
        end else begin
          ctx_d   = ctx_q + CONTEXT_SIZE_BIT_LENGTH'(1);
          state_d = ST_REQ0;
        end
      end
      ST_START: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // outputs are registered, so they are decoded from the state being entered
    memory_read_d = (state_d == ST_REQ0) || (state_d == ST_REQ1);
    if (state_d == ST_REQ0) begin
      memory_read_address_d = ptr_d;
    end else if (state_d == ST_REQ1) begin
      memory_read_address_d = ptr_q + ADDRESS_WIDTH'(1);
    end
    start_exec_d = (state_d == ST_START);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q               <= ST_IDLE;
      ptr_q                 <= '0;
      max_id_q              <= '0;
      pe_q                  <= '0;
      ctx_q                 <= '0;
      field_q               <= '0;
      memory_read_q         <= 1'b0;
      memory_read_address_q <= '0;
      write_config_data_q   <= '0;
      config_index_q        <= '0;
      config_in1_q          <= '0;
      config_in2_q          <= '0;
      config_out_q          <= '0;
      config_op_q           <= '0;
      config_const_q        <= '0;
      mapping_q             <= '0;
      start_exec_q          <= 1'b0;
      busy_q                <= 1'b0;
    end else begin
      state_q               <= state_d;
      ptr_q                 <= ptr_d;
      max_id_q              <= max_id_d;
      pe_q                  <= pe_d;
      ctx_q                 <= ctx_d;
      field_q               <= field_d;
      memory_read_q         <= memory_read_d;
      memory_read_address_q <= memory_read_address_d;
      write_config_data_q   <= write_config_data_d;
      config_index_q        <= config_index_d;
      config_in1_q          <= config_in1_d;
      config_in2_q          <= config_in2_d;
      config_out_q          <= config_out_d;
      config_op_q           <= config_op_d;
      config_const_q        <= config_const_d;
      mapping_q             <= mapping_d;
      start_exec_q          <= start_exec_d;
      busy_q                <= busy_d;
    end
  end

  assign memory_read             = memory_read_q;
  assign memory_read_address     = memory_read_address_q;
  assign write_config_data       = write_config_data_q;
  assign config_index            = config_index_q;
  assign config_input_PE_index_1 = config_in1_q;
  assign config_input_PE_index_2 = config_in2_q;
  assign config_output_PE_index  = config_out_q;
  assign config_op               = config_op_q;
  assign config_const_data       = config_const_q;
  assign mapping_context_max_id  = mapping_q;
  assign start_exec              = start_exec_q;
  assign busy                    = busy_q;

endmodule
`default_nettype wire
